// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART config APB arbiter.
// Register map of the UART bank and the request bundle.
package uart_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RDWAIT,
        S_RESP
    } arb_state_e;

    localparam logic [31:0] REG_DIV     = 32'h0000_0000;
    localparam logic [31:0] REG_PARITY  = 32'h0000_0004;
    localparam logic [31:0] REG_STOP    = 32'h0000_0008;
    localparam logic [31:0] REG_ST_RX   = 32'h0000_000C;
    localparam logic [31:0] REG_ST_DROP = 32'h0000_0010;
    localparam logic [31:0] REG_ST_STOP = 32'h0000_0014;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cfg_req_t;

endpackage

// File: rtl/uart_cfg_rr_arb.sv
// Two-way round-robin grant for the UART config APB port.
// The pointer only moves when a grant is actually taken.
module uart_cfg_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt,
    output logic       gidx
);

    logic last_q;

    always_comb begin
        gidx = 1'b0;
        gnt  = 2'b00;
        if (req == 2'b11) begin
            gidx = ~last_q;
        end else begin
            gidx = req[1];
        end
        if (take && (|req)) begin
            gnt[gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (take && (|req)) begin
            last_q <= gidx;
        end
    end

endmodule

// File: rtl/uart_cfg_apb_arb.sv
// Arbitrates two config requesters onto the UART bank APB port.
// Runs setup/access, waits out the registered-read latency, returns one response.
module uart_cfg_apb_arb
    import uart_cfg_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ-1:0][31:0]      req_addr,
    input  logic [NREQ-1:0][31:0]      req_wdata,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [31:0]                paddr,
    output logic [31:0]                pwdata,
    input  logic                       pready,
    input  logic [31:0]                prdata
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned LW = $clog2(RD_LAT + 2);
    localparam bit RD_BYPASS = (RD_LAT == 0);

    arb_state_e     state_q;
    arb_state_e     state_d;
    cfg_req_t       req_q;
    cfg_req_t       req_sel;
    logic           gidx_q;
    logic           gidx;
    logic           take;
    logic [TW-1:0]  to_cnt_q;
    logic [LW-1:0]  lat_cnt_q;
    logic [31:0]    rdata_q;
    logic           err_q;
    logic           to_last;
    logic           lat_last;

    assign take     = (state_q == S_IDLE) && (|req_valid) && !rst;
    assign to_last  = (to_cnt_q == TW'(TIMEOUT - 1));
    assign lat_last = (lat_cnt_q == LW'(RD_LAT - 1));

    uart_cfg_rr_arb u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req_valid),
        .take (take),
        .gnt  (req_ready),
        .gidx (gidx)
    );

    always_comb begin
        req_sel.write = req_write[gidx];
        req_sel.addr  = req_addr[gidx];
        req_sel.wdata = req_wdata[gidx];
    end

    always_comb begin
        state_d   = state_q;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = 32'h0;
        pwdata    = 32'h0;
        rsp_valid = '0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                psel    = 1'b1;
                pwrite  = req_q.write;
                paddr   = req_q.addr;
                pwdata  = req_q.wdata;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                pwrite  = req_q.write;
                paddr   = req_q.addr;
                pwdata  = req_q.wdata;
                if (pready) begin
                    if (req_q.write || RD_BYPASS) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_RDWAIT;
                    end
                end else if (to_last) begin
                    state_d = S_RESP;
                end
            end
            S_RDWAIT: begin
                if (lat_last) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[gidx_q] = 1'b1;
                rsp_rdata         = rdata_q;
                rsp_err           = err_q;
                state_d           = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            gidx_q    <= 1'b0;
            to_cnt_q  <= '0;
            lat_cnt_q <= '0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (take) begin
                        req_q     <= req_sel;
                        gidx_q    <= gidx;
                        to_cnt_q  <= '0;
                        lat_cnt_q <= '0;
                        rdata_q   <= 32'h0;
                        err_q     <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (pready) begin
                        if (!req_q.write && RD_BYPASS) begin
                            rdata_q <= prdata;
                        end
                    end else if (to_last) begin
                        // Bus error: reads report a recognisable marker
                        err_q <= 1'b1;
                        if (!req_q.write) begin
                            rdata_q <= ERR_DATA;
                        end
                    end
                end
                S_RDWAIT: begin
                    lat_cnt_q <= lat_cnt_q + 1'b1;
                    if (lat_last) begin
                        rdata_q <= prdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cfg_apb_arb.sv
// Directed bench for uart_cfg_apb_arb with a registered-read slave model.
// Expected responses are queued at accept and popped when rsp_valid fires.
module tb_uart_cfg_apb_arb;
    import uart_cfg_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [31:0]      paddr;
    logic [31:0]      pwdata;
    logic             pready;
    logic [31:0]      prdata = 32'h0;

    always #5 clk = ~clk;

    uart_cfg_apb_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] mem [0:7];
    int          pr_delay = 0;
    int          acc_cnt = 0;
    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    int          acc_cyc = 0;
    int          psel_cyc = 0;
    int          pen_cyc = 0;
    int          stab_err = 0;
    logic [31:0] a0 = 32'h0;
    logic [31:0] w0 = 32'h0;
    logic        wr0 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Slave: pready after pr_delay wait cycles; prdata registered on completion
    assign pready = psel & penable & (acc_cnt == pr_delay);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (psel && penable && pready) begin
            if (pwrite) mem[paddr[4:2]] <= pwdata;
            else prdata <= mem[paddr[4:2]];
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (psel) psel_cyc++;
        if (penable) begin
            if (pen_cyc == 0) begin
                a0 = paddr;
                w0 = pwdata;
                wr0 = pwrite;
            end else if (paddr !== a0 || pwdata !== w0 || pwrite !== wr0) begin
                stab_err++;
            end
            pen_cyc++;
        end
        if (rsp_valid !== 2'b00) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
                chk("rsp_rdata", rsp_rdata, e.d);
                chk("rsp_err", 32'(rsp_err), 32'(e.e));
            end
        end
    end

    task automatic issue(input int r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic e);
        exp_t x;
        int n;
        @(posedge clk);
        #1;
        req_valid[r] = 1'b1;
        req_write[r] = w;
        req_addr[r]  = a;
        req_wdata[r] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[r] && n < 200);
        chk("accept", 32'(req_ready[r]), 32'h1);
        acc_cyc = cyc;
        x.v = 2'b01 << r;
        x.e = e;
        x.d = w ? 32'h0 : (e ? ERR_DATA_DEF : mem[a[4:2]]);
        if (req_ready[r]) sb.push_back(x);
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int n0, input int lat, input string tag);
        int n;
        n = 0;
        while (rsp_cnt == n0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(rsp_cnt), 32'(n0 + 1));
        chk({tag, "_lat"}, 32'(rsp_cyc - acc_cyc), 32'(lat));
    endtask

    task automatic tie_run(input int ntx, input int first);
        int g;
        int prev;
        int n;
        exp_t x;
        prev = -1;
        @(posedge clk);
        #1;
        req_valid   = 2'b11;
        req_write   = 2'b00;
        req_addr[0] = REG_STOP;
        req_addr[1] = REG_ST_RX;
        for (int i = 0; i < ntx; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == 2'b00 && n < 50);
            g = req_ready[1] ? 1 : 0;
            chk("tie_grant", 32'(req_ready), 32'(2'b01 << ((first + i) % 2)));
            if (req_ready != 2'b00) begin
                x.v = req_ready;
                x.e = 1'b0;
                x.d = mem[req_addr[g][4:2]];
                sb.push_back(x);
            end
            if (prev >= 0) chk("tie_alternate", 32'(g != prev), 32'h1);
            prev = g;
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("tie_drain", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        mem[1] = 32'h0000_0003;
        mem[2] = 32'h0000_0011;
        mem[3] = 32'h0000_0022;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_psel", 32'(psel), 32'h0);
        chk("rst_penable", 32'(penable), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;

        // Write DIV, immediate pready
        psel_cyc = 0;
        pen_cyc  = 0;
        n0 = rsp_cnt;
        issue(0, 1'b1, REG_DIV, 32'h0000_01B2, 1'b0);
        wait_rsp(n0, 3, "wr_div");
        chk("wr_div_psel_cycles", 32'(psel_cyc), 32'd2);
        chk("wr_div_pen_cycles", 32'(pen_cyc), 32'd1);
        chk("wr_div_pwdata", w0, 32'h0000_01B2);
        chk("wr_div_pwrite", 32'(wr0), 32'h1);
        chk("wr_div_paddr", a0, REG_DIV);

        // Read PARITY from requester 1 with one-cycle registered read
        pen_cyc = 0;
        n0 = rsp_cnt;
        issue(1, 1'b0, REG_PARITY, 32'h0, 1'b0);
        wait_rsp(n0, 4, "rd_parity");
        chk("rd_parity_pwrite", 32'(wr0), 32'h0);

        // Six back-to-back tied reads alternate starting at requester 0
        tie_run(6, 0);

        // Timeout on read, then on write, then normal recovery
        pr_delay = 1000;
        pen_cyc  = 0;
        n0 = rsp_cnt;
        issue(0, 1'b0, REG_STOP, 32'h0, 1'b1);
        wait_rsp(n0, 66, "to_rd");
        chk("to_rd_access_cycles", 32'(pen_cyc), 32'd64);
        n0 = rsp_cnt;
        issue(1, 1'b1, REG_ST_STOP, 32'h0000_0077, 1'b1);
        wait_rsp(n0, 66, "to_wr");
        pr_delay = 0;
        n0 = rsp_cnt;
        issue(1, 1'b0, REG_ST_RX, 32'h0, 1'b0);
        wait_rsp(n0, 4, "to_recover");

        // pready delayed 3 cycles: stable APB fields, single response
        pr_delay = 3;
        pen_cyc  = 0;
        stab_err = 0;
        n0 = rsp_cnt;
        issue(0, 1'b1, REG_ST_DROP, 32'h0000_A5A5, 1'b0);
        wait_rsp(n0, 6, "slow_wr");
        chk("slow_wr_access_cycles", 32'(pen_cyc), 32'd4);
        chk("slow_wr_stable", 32'(stab_err), 32'h0);
        repeat (10) @(negedge clk);
        #1;
        chk("slow_wr_no_dup", 32'(rsp_cnt), 32'(n0 + 1));
        n0 = rsp_cnt;
        issue(1, 1'b0, REG_ST_DROP, 32'h0, 1'b0);
        wait_rsp(n0, 7, "slow_rd");

        // Reset while in ACCESS aborts with no response
        pr_delay = 1000;
        n0 = rsp_cnt;
        issue(0, 1'b1, REG_DIV, 32'h0000_0055, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!penable && n < 20);
        chk("abort_in_access", 32'(penable), 32'h1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_psel", 32'(psel), 32'h0);
        chk("abort_penable", 32'(penable), 32'h0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (10) @(negedge clk);
        #1;
        chk("abort_no_rsp", 32'(rsp_cnt), 32'(n0));
        pr_delay = 0;
        tie_run(2, 0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
